// File: rtl/uprocesador_pkg.sv
// rtl/uprocesador_pkg.sv - shared constants and FSM encoding for the data memory controller
package uprocesador_pkg;

  localparam int DATAWIDTH_BUS  = 32;
  localparam int MEM_WORD_SHIFT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } memCtrlState_t;

endpackage

// File: rtl/mem_ctrl_ram.sv
// rtl/mem_ctrl_ram.sv - single-port synchronous word RAM, read-before-write, no reset
module mem_ctrl_ram #(
  parameter int DATAWIDTH_BUS      = 32,
  parameter int DATAWIDTH_MEM_ADDR = 10
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [DATAWIDTH_MEM_ADDR-1:0] addr,
  input  logic [DATAWIDTH_BUS-1:0]      din,
  output logic [DATAWIDTH_BUS-1:0]      dout
);

  logic [DATAWIDTH_BUS-1:0] mem [2**DATAWIDTH_MEM_ADDR];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/data_memory_controller.sv
// rtl/data_memory_controller.sv - wait-state controller between RD/WR strobes and the data RAM
module data_memory_controller
  import uprocesador_pkg::*;
#(
  parameter int DATAWIDTH_BUS      = uprocesador_pkg::DATAWIDTH_BUS,
  parameter int DATAWIDTH_MEM_ADDR = 10,
  parameter int WAIT_STATES        = 1
) (
  input  logic                     MemCtrl_CLOCK_50,
  input  logic                     MemCtrl_Reset_InHigh,
  input  logic                     MemCtrl_RD_In,
  input  logic                     MemCtrl_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] MemCtrl_Address_In,
  input  logic [DATAWIDTH_BUS-1:0] MemCtrl_Data_In,
  output logic [DATAWIDTH_BUS-1:0] MemCtrl_Data_Out,
  output logic                     MemCtrl_Ready_Out,
  output logic                     MemCtrl_Error_Out,
  output logic                     MemCtrl_Busy_Out
);

  localparam int IDX_LO = MEM_WORD_SHIFT;
  localparam int IDX_HI = DATAWIDTH_MEM_ADDR + MEM_WORD_SHIFT - 1;

  memCtrlState_t                 state, stateNext;
  logic [3:0]                    waitCnt;
  logic [DATAWIDTH_MEM_ADDR-1:0] addrIdx;
  logic [DATAWIDTH_BUS-1:0]      dataReg;
  logic                          opWrite;
  logic                          errFlag;
  logic                          request;
  logic                          badAccess;
  logic                          ramWe;
  logic [DATAWIDTH_MEM_ADDR-1:0] ramAddr;
  logic [DATAWIDTH_BUS-1:0]      ramDout;

  always_comb begin
    request   = MemCtrl_RD_In | MemCtrl_WR_In;
    badAccess = (MemCtrl_RD_In & MemCtrl_WR_In)
              || (MemCtrl_Address_In[IDX_LO-1:0] != '0)
              || ((MemCtrl_Address_In >> (IDX_HI + 1)) != '0);
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (request) begin
          if (badAccess)             stateNext = ST_DONE;
          else if (WAIT_STATES == 0) stateNext = ST_ACCESS;
          else                       stateNext = ST_WAIT;
        end
      end
      ST_WAIT:    if (waitCnt <= 4'd1) stateNext = ST_ACCESS;
      ST_ACCESS:  stateNext = ST_DONE;
      ST_DONE:    stateNext = ST_RELEASE;
      ST_RELEASE: if (!request) stateNext = ST_IDLE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge MemCtrl_CLOCK_50 or posedge MemCtrl_Reset_InHigh) begin
    if (MemCtrl_Reset_InHigh) begin
      state             <= ST_IDLE;
      waitCnt           <= '0;
      addrIdx           <= '0;
      dataReg           <= '0;
      opWrite           <= 1'b0;
      errFlag           <= 1'b0;
      MemCtrl_Data_Out  <= '0;
      MemCtrl_Ready_Out <= 1'b0;
      MemCtrl_Error_Out <= 1'b0;
      MemCtrl_Busy_Out  <= 1'b0;
    end else begin
      state             <= stateNext;
      MemCtrl_Ready_Out <= 1'b0;
      MemCtrl_Error_Out <= 1'b0;
      MemCtrl_Busy_Out  <= (stateNext != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (request) begin
            addrIdx <= MemCtrl_Address_In[IDX_HI:IDX_LO];
            dataReg <= MemCtrl_Data_In;
            opWrite <= MemCtrl_WR_In;
            errFlag <= badAccess;
            waitCnt <= 4'(WAIT_STATES);
          end
        end
        ST_WAIT:   waitCnt <= waitCnt - 4'd1;
        ST_ACCESS: if (!opWrite) MemCtrl_Data_Out <= ramDout;
        ST_DONE: begin
          MemCtrl_Ready_Out <= 1'b1;
          MemCtrl_Error_Out <= errFlag;
        end
        default: ;
      endcase
    end
  end

  // In IDLE the RAM is addressed straight from the bus so a zero-wait read has its word ready on leaving ACCESS.
  always_comb begin
    ramWe   = (state == ST_ACCESS) && opWrite;
    ramAddr = (state == ST_IDLE) ? MemCtrl_Address_In[IDX_HI:IDX_LO] : addrIdx;
  end

  mem_ctrl_ram #(
    .DATAWIDTH_BUS      (DATAWIDTH_BUS),
    .DATAWIDTH_MEM_ADDR (DATAWIDTH_MEM_ADDR)
  ) uRam (
    .clk  (MemCtrl_CLOCK_50),
    .we   (ramWe),
    .addr (ramAddr),
    .din  (dataReg),
    .dout (ramDout)
  );

endmodule
